sar_search_ctrl: RTL and testbench

//  Successive-approximation search controller: the driving end of the magnitude comparator.

---
 rtl/sar_search_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sar_search_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_ctrl
//  Description : Successive-approximation search controller. Drives a probe
//                value onto the A side of a combinational magnitude
//                comparator and walks MSB-first towards the unknown value on
//                the B side, using the gt/eq/lt flags returned in the same
//                cycle. Converges in at most WIDTH probe cycles.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk     in   1      rising-edge clock
//    rst_n   in   1      asynchronous active-low reset
//    start   in   1      request a new search (accepted only when idle)
//    cmp_gt  in   1      comparator flag: probe > target
//    cmp_eq  in   1      comparator flag: probe == target
//    cmp_lt  in   1      comparator flag: probe < target
//    probe   out  WIDTH  candidate value presented to the comparator
//    busy    out  1      high while probing
//    done    out  1      one-cycle pulse, result/hit_eq/error valid
//    result  out  WIDTH  converged value, held until the next accepted start
//    hit_eq  out  1      search ended on an equal flag
//    error   out  1      comparator flags were not one-hot
// ============================================================================
module sar_search_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_gt,
   input  logic             cmp_eq,
   input  logic             cmp_lt,
   output logic [WIDTH-1:0] probe,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             hit_eq,
   output logic             error
);

   localparam int K_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PROBE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state,  w_state_nxt;
   logic [K_W-1:0]   r_k,      w_k_nxt;
   logic [WIDTH-1:0] r_probe,  w_probe_nxt;
   logic [WIDTH-1:0] r_result, w_result_nxt;
   logic             r_busy,   w_busy_nxt;
   logic             r_done,   w_done_nxt;
   logic             r_hit_eq, w_hit_eq_nxt;
   logic             r_error,  w_error_nxt;

   logic [2:0]       w_flags;
   logic             w_onehot;
   logic [WIDTH-1:0] w_probe_upd;

   assign w_flags  = {cmp_gt, cmp_eq, cmp_lt};
   assign w_onehot = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_k      <= '0;
         r_probe  <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hit_eq <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_k      <= w_k_nxt;
         r_probe  <= w_probe_nxt;
         r_result <= w_result_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_hit_eq <= w_hit_eq_nxt;
         r_error  <= w_error_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt  = r_state;
      w_k_nxt      = r_k;
      w_probe_nxt  = r_probe;
      w_result_nxt = r_result;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;              // done is a single-cycle pulse
      w_hit_eq_nxt = r_hit_eq;
      w_error_nxt  = r_error;
      w_probe_upd  = r_probe;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt  = S_PROBE;
               w_probe_nxt  = {1'b1, {(WIDTH-1){1'b0}}};
               w_k_nxt      = K_W'(WIDTH-1);
               w_busy_nxt   = 1'b1;
               w_hit_eq_nxt = 1'b0;
               w_error_nxt  = 1'b0;
               w_result_nxt = '0;
            end
         end

         S_PROBE: begin
            if (!w_onehot) begin
               w_error_nxt  = 1'b1;
               w_result_nxt = '0;
               w_busy_nxt   = 1'b0;
               w_done_nxt   = 1'b1;
               w_state_nxt  = S_DONE;
            end else if (cmp_eq) begin
               w_result_nxt = r_probe;
               w_hit_eq_nxt = 1'b1;
               w_busy_nxt   = 1'b0;
               w_done_nxt   = 1'b1;
               w_state_nxt  = S_DONE;
            end else begin
               // Probe overshot: this bit must be 0 in the target.
               if (cmp_gt) begin
                  w_probe_upd[r_k] = 1'b0;
               end
               if (r_k != '0) begin
                  w_probe_upd[r_k - K_W'(1)] = 1'b1;
                  w_k_nxt = r_k - K_W'(1);
               end else begin
                  // Bit 0 decided: the updated probe is the answer.
                  w_result_nxt = w_probe_upd;
                  w_busy_nxt   = 1'b0;
                  w_done_nxt   = 1'b1;
                  w_state_nxt  = S_DONE;
               end
               w_probe_nxt = w_probe_upd;
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign probe  = r_probe;
   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign hit_eq = r_hit_eq;
   assign error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sar_search_ctrl
//  Description : Directed self-checking bench for sar_search_ctrl. A
//                behavioural comparator derives the flags from the probe and
//                a bench-held target; flags can be overridden to inject
//                malformed patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       cmp_gt;
   logic       cmp_eq;
   logic       cmp_lt;
   logic [3:0] probe;
   logic       busy;
   logic       done;
   logic [3:0] result;
   logic       hit_eq;
   logic       error;

   logic [3:0] target;
   logic       ovr_en;
   logic [2:0] ovr_flags;

   int n_checks;
   int n_errors;

   sar_search_ctrl #(.WIDTH(4)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .cmp_gt (cmp_gt),
      .cmp_eq (cmp_eq),
      .cmp_lt (cmp_lt),
      .probe  (probe),
      .busy   (busy),
      .done   (done),
      .result (result),
      .hit_eq (hit_eq),
      .error  (error)
   );

   // Reference comparator, with an override path for malformed flags
   assign cmp_gt = ovr_en ? ovr_flags[2] : (probe >  target);
   assign cmp_eq = ovr_en ? ovr_flags[1] : (probe == target);
   assign cmp_lt = ovr_en ? ovr_flags[0] : (probe <  target);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a search and follow it to its done pulse.
   // seq holds the expected probes, first in the top nibble; n is the
   // number of probe cycles. hold keeps start asserted afterwards.
   task automatic run_search(input logic [3:0] tgt, input logic [15:0] seq, input int n,
                             input logic [3:0] exp_res, input logic exp_hit, input bit hold);
      target = tgt;
      start  = 1'b1;
      tick();
      start  = hold;
      chk("accept_result", result, 4'd0);
      chk("accept_hit", hit_eq, 1'b0);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("probe%0d_t%0d", i + 1, tgt), probe, seq[15-4*i -: 4]);
         chk("busy_probe", busy, 1'b1);
         chk("done_early", done, 1'b0);
         tick();
      end
      chk($sformatf("done_t%0d", tgt), done, 1'b1);
      chk("busy_done", busy, 1'b0);
      chk($sformatf("result_t%0d", tgt), result, exp_res);
      chk($sformatf("hit_t%0d", tgt), hit_eq, exp_hit);
      chk("error_clean", error, 1'b0);
      tick();
      chk("done_pulse", done, 1'b0);
      chk("result_held", result, exp_res);
      chk("hit_held", hit_eq, exp_hit);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_probe"}, probe, 4'd0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_result"}, result, 4'd0);
      chk({tag, "_hit"}, hit_eq, 1'b0);
      chk({tag, "_error"}, error, 1'b0);
   endtask

   task automatic bad_flags(input logic [2:0] flags);
      target    = 4'd3;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      ovr_en    = 1'b1;
      ovr_flags = flags;
      chk("err_probe1", probe, 4'd8);
      tick();
      ovr_en    = 1'b0;
      chk("err_done", done, 1'b1);
      chk("err_flag", error, 1'b1);
      chk("err_result", result, 4'd0);
      chk("err_busy", busy, 1'b0);
      chk("err_hit", hit_eq, 1'b0);
      chk("err_probe_hold", probe, 4'd8);
      tick();
      chk("err_done_pulse", done, 1'b0);
      chk("err_held", error, 1'b1);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      target    = 4'd0;
      ovr_en    = 1'b0;
      ovr_flags = 3'b000;

      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();
      check_all_zero("idle");

      // Ordinary convergence cases
      run_search(4'd11, 16'h8CAB, 4, 4'd11, 1'b1, 1'b0);
      run_search(4'd8,  16'h8000, 1, 4'd8,  1'b1, 1'b0);
      run_search(4'd0,  16'h8421, 4, 4'd0,  1'b0, 1'b0);
      chk("t0_final_probe", probe, 4'd0);
      run_search(4'd15, 16'h8CEF, 4, 4'd15, 1'b1, 1'b0);
      run_search(4'd5,  16'h8465, 4, 4'd5,  1'b1, 1'b0);
      run_search(4'd6,  16'h8460, 3, 4'd6,  1'b1, 1'b0);

      // Malformed comparator flags
      bad_flags(3'b000);
      bad_flags(3'b110);

      // Start held through PROBE and DONE: ignored until back in IDLE
      run_search(4'd11, 16'h8CAB, 4, 4'd11, 1'b1, 1'b1);
      tick();
      chk("restart_busy", busy, 1'b1);
      chk("restart_probe", probe, 4'd8);
      chk("restart_result", result, 4'd0);
      chk("restart_hit", hit_eq, 1'b0);
      start = 1'b0;

      // Reset in the middle of that search, after probe 2
      tick();
      chk("mid_probe2", probe, 4'd12);
      tick();
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_no_done", done, 1'b0);
      end
      rst_n = 1'b1;
      tick();
      check_all_zero("post_rst");
      run_search(4'd13, 16'h8CED, 4, 4'd13, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
